// File: rtl/intr_source_conditioner.sv
// Interrupt source conditioner: synchronises raw lines, applies polarity and
// level/edge mode, latches pending, masks with ENABLE and registers the result.
module intr_source_conditioner #(
  parameter int unsigned NUM_INTR    = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                pclk_i,
  input  logic                prst_n_i,
  input  logic                psel_i,
  input  logic                penable_i,
  input  logic                pwrite_i,
  input  logic [7:0]          paddr_i,
  input  logic [7:0]          pwdata_i,
  output logic [7:0]          prdata_o,
  output logic                pready_o,
  output logic                pslverr_o,
  input  logic [NUM_INTR-1:0] irq_raw_i,
  input  logic                intr_serviced_i,
  input  logic [3:0]          intr_serviced_id_i,
  output logic [NUM_INTR-1:0] intr_active_o
);

  logic [NUM_INTR-1:0] sync_q [SYNC_STAGES];
  logic [NUM_INTR-1:0] sync_d [SYNC_STAGES];
  logic [NUM_INTR-1:0] enable_q, enable_d;
  logic [NUM_INTR-1:0] mode_q, mode_d;
  logic [NUM_INTR-1:0] polarity_q, polarity_d;
  logic [NUM_INTR-1:0] pending_q, pending_d;
  logic [NUM_INTR-1:0] prev_q, prev_d;
  logic [NUM_INTR-1:0] active_q, active_d;

  logic                access;
  logic                mapped;
  logic                read_only;
  logic                wr_ok;
  logic [NUM_INTR-1:0] wr_mask;
  logic [NUM_INTR-1:0] wr_val;
  logic [NUM_INTR-1:0] cond;
  logic [NUM_INTR-1:0] edge_set;
  logic [NUM_INTR-1:0] w1c_mask;
  logic [NUM_INTR-1:0] svc_mask;
  logic [NUM_INTR-1:0] rd_reg;

  // Access is gated by reset so the bus outputs read 0 while held in reset.
  always_comb begin
    access    = psel_i & penable_i & prst_n_i;
    mapped    = (paddr_i <= 8'h09);
    read_only = (paddr_i[7:1] == 7'd4);
    wr_ok     = access & pwrite_i & mapped & ~read_only;
    pready_o  = access;
    pslverr_o = access & (~mapped | (pwrite_i & read_only));
  end

  always_comb begin
    wr_mask = {{8{paddr_i[0]}}, {8{~paddr_i[0]}}};
    wr_val  = {pwdata_i, pwdata_i};
  end

  always_comb begin
    sync_d[0] = irq_raw_i;
    for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  always_comb begin
    cond     = sync_q[SYNC_STAGES-1] ^ polarity_q;
    edge_set = cond & ~prev_q;
    w1c_mask = '0;
    if (wr_ok && (paddr_i[7:1] == 7'd3)) begin
      w1c_mask = wr_val & wr_mask;
    end
    svc_mask = '0;
    if (intr_serviced_i) begin
      svc_mask[intr_serviced_id_i] = 1'b1;
    end
    // Edge lines: a new edge beats any clear arriving in the same cycle.
    pending_d = (mode_q & (edge_set | (pending_q & ~(w1c_mask | svc_mask))))
              | (~mode_q & cond);
    prev_d    = cond;
    active_d  = pending_q & enable_q;
  end

  always_comb begin
    enable_d   = enable_q;
    mode_d     = mode_q;
    polarity_d = polarity_q;
    if (wr_ok) begin
      unique case (paddr_i[7:1])
        7'd0:    enable_d   = (enable_q & ~wr_mask) | (wr_val & wr_mask);
        7'd1:    mode_d     = (mode_q & ~wr_mask) | (wr_val & wr_mask);
        7'd2:    polarity_d = (polarity_q & ~wr_mask) | (wr_val & wr_mask);
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_reg = '0;
    case (paddr_i[7:1])
      7'd0:    rd_reg = enable_q;
      7'd1:    rd_reg = mode_q;
      7'd2:    rd_reg = polarity_q;
      7'd3:    rd_reg = pending_q;
      7'd4:    rd_reg = pending_q & enable_q;
      default: rd_reg = '0;
    endcase
    prdata_o = '0;
    if (access && !pwrite_i && mapped) begin
      prdata_o = paddr_i[0] ? rd_reg[15:8] : rd_reg[7:0];
    end
  end

  always_ff @(posedge pclk_i or negedge prst_n_i) begin
    if (!prst_n_i) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      enable_q   <= '0;
      mode_q     <= '0;
      polarity_q <= '0;
      pending_q  <= '0;
      prev_q     <= '0;
      active_q   <= '0;
    end else begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_d[i];
      end
      enable_q   <= enable_d;
      mode_q     <= mode_d;
      polarity_q <= polarity_d;
      pending_q  <= pending_d;
      prev_q     <= prev_d;
      active_q   <= active_d;
    end
  end

  assign intr_active_o = active_q;

endmodule

// File: tb/tb_intr_source_conditioner.sv
// Self-checking bench for intr_source_conditioner: behavioural model compared
// every cycle, directed scenarios with literal expectations, then random traffic.
module tb_intr_source_conditioner;
  localparam int N = 16;
  localparam int S = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [7:0]  paddr = '0, pwdata = '0;
  logic [7:0]  prdata_o;
  logic        pready_o, pslverr_o;
  logic [N-1:0] irq_raw = '0;
  logic        serviced = 1'b0;
  logic [3:0]  sid = '0;
  logic [N-1:0] intr_active_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  intr_source_conditioner #(.NUM_INTR(N), .SYNC_STAGES(S)) dut (
    .pclk_i(clk), .prst_n_i(rst_n), .psel_i(psel), .penable_i(penable),
    .pwrite_i(pwrite), .paddr_i(paddr), .pwdata_i(pwdata), .prdata_o(prdata_o),
    .pready_o(pready_o), .pslverr_o(pslverr_o), .irq_raw_i(irq_raw),
    .intr_serviced_i(serviced), .intr_serviced_id_i(sid),
    .intr_active_o(intr_active_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: registers as plain variables, raw lines delayed S edges.
  logic [N-1:0] m_en = '0, m_mode = '0, m_pol = '0, m_pend = '0, m_prev = '0, m_act = '0;
  logic [N-1:0] hist [$];

  function automatic logic [7:0] exp_rd(input logic [7:0] a);
    logic [N-1:0] r;
    if (a > 8'h09) return 8'h00;
    case (a[7:1])
      7'd0:    r = m_en;
      7'd1:    r = m_mode;
      7'd2:    r = m_pol;
      7'd3:    r = m_pend;
      default: r = m_pend & m_en;
    endcase
    return a[0] ? r[15:8] : r[7:0];
  endfunction

  function automatic logic [N-1:0] set_byte(input logic [N-1:0] r, input logic hi, input logic [7:0] v);
    return hi ? {v, r[7:0]} : {r[15:8], v};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    logic [N-1:0] sync_out, cond, np, w1c;
    logic         wr_ok;
    if (!rst_n) begin
      m_en = '0; m_mode = '0; m_pol = '0; m_pend = '0; m_prev = '0; m_act = '0;
      hist.delete();
      repeat (S) hist.push_back('0);
    end else begin
      sync_out = hist.pop_front();
      hist.push_back(irq_raw);
      cond  = sync_out ^ m_pol;
      wr_ok = psel && penable && pwrite && (paddr < 8'h08);
      w1c   = '0;
      if (wr_ok && paddr[7:1] == 7'd3)
        w1c = paddr[0] ? {pwdata, 8'h00} : {8'h00, pwdata};
      for (int i = 0; i < N; i++) begin
        if (!m_mode[i])                      np[i] = cond[i];
        else if (cond[i] && !m_prev[i])      np[i] = 1'b1;
        else if (w1c[i] || (serviced && int'(sid) == i)) np[i] = 1'b0;
        else                                 np[i] = m_pend[i];
      end
      m_act  = m_pend & m_en;
      m_pend = np;
      m_prev = cond;
      if (wr_ok) begin
        case (paddr[7:1])
          7'd0: m_en   = set_byte(m_en, paddr[0], pwdata);
          7'd1: m_mode = set_byte(m_mode, paddr[0], pwdata);
          7'd2: m_pol  = set_byte(m_pol, paddr[0], pwdata);
          default: ;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    logic acc;
    acc = psel && penable && rst_n;
    chk("intr_active", intr_active_o, m_act);
    chk("pready", pready_o, acc);
    chk("pslverr", pslverr_o, acc && ((paddr > 8'h09) || (pwrite && paddr >= 8'h08)));
    chk("prdata", prdata_o, (acc && !pwrite) ? exp_rd(paddr) : 8'h00);
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic apb_write(input logic [7:0] a, input logic [7:0] v, output logic e);
    psel = 1'b1; pwrite = 1'b1; paddr = a; pwdata = v; penable = 1'b0;
    step();
    penable = 1'b1;
    #1 e = pslverr_o;
    step();
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [7:0] a, output logic [7:0] d, output logic e);
    psel = 1'b1; pwrite = 1'b0; paddr = a; penable = 1'b0;
    step();
    penable = 1'b1;
    #1 begin d = prdata_o; e = pslverr_o; end
    step();
    psel = 1'b0; penable = 1'b0;
  endtask

  initial begin
    logic [7:0] d;
    logic       e;
    repeat (3) step();
    rst_n = 1'b1;
    step();

    for (int a = 0; a < 10; a++) begin
      apb_read(8'(a), d, e);
      chk("reset_read", d, 8'h00);
      chk("reset_read_err", e, 1'b0);
    end
    apb_read(8'h0A, d, e);
    chk("unmapped_err", e, 1'b1);
    chk("unmapped_data", d, 8'h00);

    // Level line 0: active follows raw with three edges of latency.
    apb_write(8'h00, 8'h01, e);
    irq_raw[0] = 1'b1;
    repeat (3) step();
    chk("level_rise_early", intr_active_o, 16'h0000);
    step();
    chk("level_rise", intr_active_o, 16'h0001);
    chk("model_level_rise", m_act, 16'h0001);
    irq_raw[0] = 1'b0;
    repeat (3) step();
    chk("level_fall_early", intr_active_o, 16'h0001);
    step();
    chk("level_fall", intr_active_o, 16'h0000);

    // Edge line 5: pulse latches, service clears.
    apb_write(8'h02, 8'h20, e);
    apb_write(8'h00, 8'h20, e);
    irq_raw[5] = 1'b1;
    repeat (2) step();
    irq_raw[5] = 1'b0;
    repeat (4) step();
    apb_read(8'h06, d, e);
    chk("edge_pending", d, 8'h20);
    chk("edge_active", intr_active_o, 16'h0020);
    repeat (5) step();
    chk("edge_persist", intr_active_o, 16'h0020);
    serviced = 1'b1; sid = 4'd5;
    step();
    serviced = 1'b0;
    chk("svc_one_edge", intr_active_o, 16'h0020);
    step();
    chk("svc_two_edges", intr_active_o, 16'h0000);
    chk("model_svc", m_act, 16'h0000);

    // Line 9: edge set in the same cycle as its W1C; set wins.
    apb_write(8'h03, 8'h02, e);
    irq_raw[9] = 1'b1;
    step();
    apb_write(8'h07, 8'h02, e);
    chk("w1c_err", e, 1'b0);
    apb_read(8'h07, d, e);
    chk("set_wins", d, 8'h02);
    apb_write(8'h07, 8'h02, e);
    apb_read(8'h07, d, e);
    chk("w1c_clears", d, 8'h00);

    // Line 12: falling-edge with mask off, then enable.
    apb_write(8'h03, 8'h12, e);
    apb_write(8'h05, 8'h10, e);
    repeat (4) step();
    apb_write(8'h07, 8'h10, e);
    irq_raw[12] = 1'b1;
    repeat (4) step();
    apb_read(8'h07, d, e);
    chk("pol_rise_no_edge", d, 8'h00);
    irq_raw[12] = 1'b0;
    repeat (4) step();
    apb_read(8'h07, d, e);
    chk("pol_fall_pending", d, 8'h10);
    chk("masked_active", intr_active_o, 16'h0000);
    apb_write(8'h01, 8'h10, e);
    chk("enable_pre_edge", intr_active_o, 16'h0000);
    step();
    chk("enable_active", intr_active_o, 16'h1000);
    chk("model_enable", m_act, 16'h1000);

    // Read-only ACTIVE register.
    apb_read(8'h09, d, e);
    chk("active_hi", d, 8'h10);
    apb_write(8'h08, 8'hFF, e);
    chk("ro_err", e, 1'b1);
    apb_read(8'h08, d, e);
    chk("ro_lo_unchanged", d, 8'h00);
    apb_read(8'h09, d, e);
    chk("ro_hi_unchanged", d, 8'h10);

    // Asynchronous reset in the middle of a cycle.
    chk("pre_reset_active", intr_active_o, 16'h1000);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_active", intr_active_o, 16'h0000);
    chk("model_async_reset", m_act, 16'h0000);
    repeat (2) step();
    rst_n = 1'b1;
    step();
    apb_read(8'h03, d, e);
    chk("reset_mode_hi", d, 8'h00);
    irq_raw = '0;

    // Random traffic against the model.
    for (int it = 0; it < 3000; it++) begin
      for (int b = 0; b < N; b++)
        if ($urandom_range(0, 15) == 0) irq_raw[b] = ~irq_raw[b];
      case ($urandom_range(0, 9))
        0, 1: apb_write(8'($urandom_range(0, 11)), 8'($urandom), e);
        2:    apb_read(8'($urandom_range(0, 11)), d, e);
        3: begin
          serviced = 1'b1;
          sid = 4'($urandom_range(0, 15));
          step();
          serviced = 1'b0;
        end
        default: step();
      endcase
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/intr_source_conditioner.md
Name: intr_source_conditioner

Overview:
- Upstream stage of the priority interrupt controller. Conditions NUM_INTR raw peripheral interrupt lines and presents the result on intr_active_o, which connects directly to the controller's intr_active_i.
- Conditioning steps: synchronisation, per-line polarity, per-line level/edge mode, a pending latch and an enable mask.
- Programmed over the same 8-bit APB-style bus as the controller.
- Consumes the controller's service acknowledge to auto-clear edge-latched pending bits.

Parameters:
- NUM_INTR, 16, number of interrupt lines; fixed at 16 for this address map.
- SYNC_STAGES, 2, flops in each raw-input synchroniser; minimum 2.

Ports:
- pclk_i  in  1  clock.
- prst_n_i  in  1  asynchronous, active-low reset.
- psel_i  in  1  APB select.
- penable_i  in  1  APB access phase.
- pwrite_i  in  1  1 = write, 0 = read.
- paddr_i  in  8  register address.
- pwdata_i  in  8  write data.
- prdata_o  out  8  read data.
- pready_o  out  1  transfer complete.
- pslverr_o  out  1  transfer error.
- irq_raw_i  in  NUM_INTR  asynchronous interrupt lines from peripherals.
- intr_serviced_i  in  1  one-cycle pulse from the controller: interrupt serviced.
- intr_serviced_id_i  in  4  number of the serviced interrupt.
- intr_active_o  out  NUM_INTR  conditioned active interrupts, to the controller.

Behaviour:
- Reset: prst_n_i low clears every flop immediately, without waiting for a clock edge.
  - Synchronisers, edge history, ENABLE, MODE, POLARITY and PENDING all go to 0.
  - intr_active_o = 0, prdata_o = 0, pready_o = 0, pslverr_o = 0.
  - Reset asserted mid-operation drops intr_active_o to 0 in the same cycle.
- APB timing: zero-wait.
  - pready_o = psel_i & penable_i.
  - Register writes occur on the clock edge that ends the access phase.
  - prdata_o drives the addressed register during a read access phase and 0 at all other times.
  - pslverr_o = access phase & (unmapped address, or write to a read-only address). An erroring write has no effect.
- Register map (low byte = lines 7:0, high byte = lines 15:8):
  - 0x00/0x01 ENABLE: RW.
  - 0x02/0x03 MODE: RW; 1 = edge, 0 = level.
  - 0x04/0x05 POLARITY: RW; 1 = active-low / falling edge.
  - 0x06/0x07 PENDING: read returns pending; write is write-1-to-clear, edge-mode bits only.
  - 0x08/0x09 ACTIVE: RO; reads pending & ENABLE.
- Conditioning per line:
  - cond = sync_out ^ POLARITY.
  - prev is a flop that captures cond every cycle.
- Pending, level mode: pending tracks cond every cycle; W1C and service clears are ignored.
- Pending, edge mode:
  - Set when cond & ~prev.
  - Cleared by a W1C write or by intr_serviced_i with intr_serviced_id_i == line.
  - Stays set otherwise.
  - Set and clear in the same cycle: set wins, and the bit remains 1.
- Masking: a disabled line still latches pending and asserts intr_active_o as soon as ENABLE is set. Clearing ENABLE drops intr_active_o on the next edge; pending is unaffected.
- Output: intr_active_o is registered as pending & ENABLE.
- Latency, SYNC_STAGES = 2:
  - Raw change captured at edge E0.
  - Pending updates at E2.
  - intr_active_o updates at E3.
  - In general, intr_active_o updates SYNC_STAGES+1 edges after capture.
- Mode/polarity changes:
  - A POLARITY write can create an edge on the next cycle. Software clears PENDING after any POLARITY or MODE write.
  - Switching a line from edge to level overwrites its pending bit with cond on the next edge.
- Glitches: a raw pulse shorter than one clock period may be missed; this is permitted.
- Service of an interrupt number whose line is in level mode has no effect.

Test Plan:
- Reset, then read 0x00–0x09 → all 0x00, pslverr_o = 0. Read 0x0A → pslverr_o = 1, prdata_o = 0.
- Level line: write ENABLE 0x01. Raise irq_raw_i[0] before edge E0 → intr_active_o = 0x0001 after E3. Drop irq_raw_i[0] → intr_active_o = 0x0000 three edges later.
- Edge line: write MODE 0x20 and ENABLE 0x20. Give irq_raw_i[5] a 2-cycle pulse → PENDING reads 0x20 and intr_active_o[5] = 1 persists. Pulse intr_serviced_i with id 5 → intr_active_o[5] = 0 two edges later.
- Simultaneous set/clear: new rising edge on line 9 (edge mode) in the same cycle as W1C 0x02 to 0x07 → PENDING high byte still reads 0x02.
- Mask and polarity: line 12 in edge mode with POLARITY = 1 and ENABLE = 0. Falling edge on line 12 → PENDING[12] = 1, intr_active_o = 0. Write ENABLE high byte 0x10 → intr_active_o[12] = 1 on the next edge.
- Read-only protection and async reset: write 0xFF to 0x08 → pslverr_o = 1, ACTIVE unchanged. Assert prst_n_i low mid-cycle while lines are active → intr_active_o = 0 before the next clock edge.
